// File: rtl/router_pkg.sv
// Shared types and constants for the router packet transmitter.
// Holds the FSM state encoding, header field widths and error mask.
package router_pkg;

  localparam int ROUTER_MAX_LEN = 63;
  localparam int ROUTER_LEN_W = 6;
  localparam int ROUTER_ADDR_W = 2;
  localparam logic [7:0] ROUTER_ERR_MASK = 8'h05;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_HEADER,
    ST_PAYLOAD,
    ST_PARITY,
    ST_GAP
  } tx_state_t;

  function automatic logic [7:0] router_hdr(
    input logic [ROUTER_LEN_W-1:0] len,
    input logic [ROUTER_ADDR_W-1:0] addr
  );
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// Command, payload-write and router-side signals of the transmitter.
// slave is the transmitter side, master is the producer/router side.
interface router_pkt_tx_if;
  import router_pkg::*;

  logic cmd_valid;
  logic cmd_ready;
  logic [ROUTER_LEN_W-1:0] cmd_len;
  logic [ROUTER_ADDR_W-1:0] cmd_addr;
  logic wr_en;
  logic [7:0] wr_data;
  logic wr_full;
  logic busy;
  logic pkt_valid;
  logic [7:0] data_out;
  logic tx_done;

  modport master (
    output cmd_valid, cmd_len, cmd_addr,
    output wr_en, wr_data, busy,
    input cmd_ready, wr_full,
    input pkt_valid, data_out, tx_done
  );

  modport slave (
    input cmd_valid, cmd_len, cmd_addr,
    input wr_en, wr_data, busy,
    output cmd_ready, wr_full,
    output pkt_valid, data_out, tx_done
  );

endinterface

// File: rtl/router_tx_fifo.sv
// Synchronous byte FIFO holding payload for the transmitter.
// Push while full is dropped; pointers wrap modulo DEPTH.
module router_tx_fifo #(
  parameter int DEPTH = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  logic [7:0] wr_data,
  input  logic pop,
  output logic [7:0] rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic push_ok;
  logic pop_ok;

  assign full = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy; simultaneous push and pop keep count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push_ok, pop_ok})
        2'b10: count <= count + CW'(1);
        2'b01: count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/router_pkt_tx.sv
// Packet transmitter: header, payload and parity to the router port.
// Define ROUTER_TX_ERR_INJ_EN to add the err_inj parity-corruption input.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int FIFO_DEPTH = 64,
  parameter int MIN_GAP = 1
) (
  input logic clock,
  input logic reset,
`ifdef ROUTER_TX_ERR_INJ_EN
  input logic err_inj,
`endif
  router_pkt_tx_if.slave bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

  tx_state_t state_q, state_d;
  logic [ROUTER_LEN_W-1:0] len_q, len_d;
  logic [ROUTER_ADDR_W-1:0] addr_q, addr_d;
  logic [ROUTER_LEN_W-1:0] cnt_q, cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] dout_q, dout_d;
  logic pv_q, pv_d;
  logic done_q, done_d;
  logic err_q, err_d;
  logic err_in;
  logic [7:0] hdr;
  logic [7:0] parity_out;

  logic fifo_pop;
  logic [7:0] fifo_rd;
  logic [CW-1:0] fifo_count;
  logic fifo_full;
  logic fifo_empty;

`ifdef ROUTER_TX_ERR_INJ_EN
  assign err_in = err_inj;
`else
  assign err_in = 1'b0;
`endif

  router_tx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(bus.wr_en),
    .wr_data(bus.wr_data),
    .pop(fifo_pop),
    .rd_data(fifo_rd),
    .count(fifo_count),
    .full(fifo_full),
    .empty(fifo_empty)
  );

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.wr_full = fifo_full;
  assign bus.pkt_valid = pv_q;
  assign bus.data_out = dout_q;
  assign bus.tx_done = done_q;

  assign hdr = router_hdr(len_q, addr_q);
  // Injected error only alters the byte sent, never the accumulator.
  assign parity_out = acc_q ^ (err_q ? ROUTER_ERR_MASK : 8'h00);

  // Next-state and next-output decode; busy freezes emission states.
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    addr_d = addr_q;
    cnt_d = cnt_q;
    gap_d = gap_q;
    acc_d = acc_q;
    dout_d = dout_q;
    pv_d = pv_q;
    done_d = 1'b0;
    err_d = err_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          len_d = bus.cmd_len;
          addr_d = bus.cmd_addr;
          err_d = err_in;
          acc_d = 8'h00;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (fifo_count >= CW'(len_q)) begin
          dout_d = hdr;
          pv_d = 1'b1;
          acc_d = hdr;
          cnt_d = '0;
          state_d = ST_HEADER;
        end
      end
      ST_HEADER, ST_PAYLOAD: begin
        if (!bus.busy) begin
          if (cnt_q == len_q) begin
            dout_d = parity_out;
            pv_d = 1'b0;
            state_d = ST_PARITY;
          end else if (!fifo_empty) begin
            fifo_pop = 1'b1;
            dout_d = fifo_rd;
            acc_d = acc_q ^ fifo_rd;
            cnt_d = cnt_q + ROUTER_LEN_W'(1);
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PARITY: begin
        if (!bus.busy) begin
          done_d = 1'b1;
          dout_d = 8'h00;
          gap_d = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == GW'(MIN_GAP - 1)) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any packet.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      len_q <= '0;
      addr_q <= '0;
      cnt_q <= '0;
      gap_q <= '0;
      acc_q <= 8'h00;
      dout_q <= 8'h00;
      pv_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      addr_q <= addr_d;
      cnt_q <= cnt_d;
      gap_q <= gap_d;
      acc_q <= acc_d;
      dout_q <= dout_d;
      pv_q <= pv_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end

endmodule

// File: doc/router_pkt_tx.md
# router_pkt_tx

Packet transmitter for the 1X3 router input port. It buffers payload bytes from an upstream producer and accepts a packet command (length, destination). It then drives a complete packet onto the router's `pkt_valid`/`data_in` interface as header, payload and parity, honouring the router's `busy` back-pressure. It sits in front of the router in system benches and traffic-source tiles, producing exactly the byte sequence the router's register stage checks.

## Interface
- `FIFO_DEPTH`, 64, payload buffer depth in bytes; power of two, ≥64 so a maximum-length packet fits.
- `MIN_GAP`, 1, idle cycles forced between packets (≥1).

Ports:
- `clock`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  packet command offered.
- `cmd_ready`  out  1  command accepted on edge where `cmd_valid & cmd_ready`.
- `cmd_len`  in  6  payload length L, 0..63.
- `cmd_addr`  in  2  destination; 3 is reserved, passed through unchanged.
- `wr_en`  in  1  push `wr_data` into payload buffer.
- `wr_data`  in  8  payload byte.
- `wr_full`  out  1  buffer full; writes ignored while high.
- `busy`  in  1  router back-pressure; outputs hold when high at an edge.
- `pkt_valid`  out  1  high during header and payload bytes.
- `data_out`  out  8  byte to router `data_in`.
- `tx_done`  out  1  one-cycle pulse after parity byte accepted.

## Operation
- Header byte = {`cmd_len`, `cmd_addr`}; parity = XOR of header and all L payload bytes.
- FSM states: IDLE, WAIT, HEADER, PAYLOAD, PARITY, GAP.
- IDLE: `cmd_ready`=1. Command accepted → latch len/addr, clear parity accumulator, go to WAIT.
- WAIT: leave when buffer count ≥ L. Go to HEADER with header registered onto `data_out`, `pkt_valid`=1.
- HEADER/PAYLOAD: advance one byte per edge with `busy`=0. Payload bytes are popped from the buffer in write order. After the L-th payload byte is accepted, go to PARITY (L=0: HEADER goes straight to PARITY).
- PARITY: `pkt_valid`=0, `data_out`=parity. Held until an edge with `busy`=0. Then `tx_done` pulses and the FSM goes to GAP.
- GAP: `pkt_valid`=0, `data_out`=0 for `MIN_GAP` cycles, then IDLE.
- `busy`=1 at an edge: state, `data_out`, `pkt_valid`, and buffer read pointer are all unchanged. No byte is skipped or duplicated.
- Buffer accepts writes in every state, including mid-packet. Simultaneous push and pop is legal; the count is unchanged. `wr_en` while `wr_full` is dropped silently.
- Count width is clog2(`FIFO_DEPTH`)+1; pointers wrap modulo `FIFO_DEPTH`.

## Timing
- All outputs are registered except `cmd_ready` and `wr_full`, which are decoded from state and count.
- Reset values: `pkt_valid`=0, `data_out`=8'h00, `tx_done`=0, `cmd_ready`=1 after release, `wr_full`=0. Buffer is emptied and FSM is in IDLE.
- Data already buffered: the header appears on the first edge after command acceptance.
- Without back-pressure, a packet occupies exactly L+2 cycles (L+1 with `pkt_valid`=1, then 1 parity cycle).
- Each cycle of `busy` high adds one cycle to the packet.
- Reset asserted mid-packet: outputs return to reset values immediately (asynchronously). The partial packet is abandoned and the buffer is cleared.

## Configuration
- `ROUTER_TX_ERR_INJ_EN` defined: adds input port `err_inj` (1 bit), sampled on command acceptance. If set, the transmitted parity is the correct parity XOR 8'h05, and the internal accumulator is unaffected.
- `ROUTER_TX_ERR_INJ_EN` undefined: the port is absent and parity is always correct.

## Structure
- Shared package `router_pkg`: FSM state enum, `ROUTER_MAX_LEN`=63, `ROUTER_ERR_MASK`=8'h05, header field widths.
- One sub-module: `router_tx_fifo`, the synchronous byte FIFO with count, full and empty flags and async active-high reset. The top level holds the FSM, parity accumulator and output registers.

## Test plan
- Preload 0x01..0x08, cmd len 8 addr 0, busy 0 → data_out 0x20, 0x01..0x08 with pkt_valid=1 (9 cycles), then 0x28 with pkt_valid=0; tx_done pulses once.
- Cmd len 5 addr 2, busy high 3 cycles while the 2nd payload byte is on data_out → header 0x16; that byte is held 4 cycles; all 5 bytes appear exactly once; parity is correct.
- Cmd len 4 accepted with buffer empty, one byte written every 2 cycles → pkt_valid stays 0 until the edge after the 4th write.
- Write 65 bytes into an empty buffer with FIFO_DEPTH 64 → wr_full after the 64th write, 65th byte dropped. A following len-63 packet leaves exactly 1 byte buffered.
- Reset pulsed during payload of a len-8 packet → pkt_valid falls with reset; cmd_ready=1 after release; next cmd waits for fresh data.
- With ROUTER_TX_ERR_INJ_EN, err_inj=1, len 0 addr 1 → data_out 0x01 then parity 0x04; the next packet with err_inj=0 has correct parity.
